// File: rtl/float_div.sv
// float_div: multicycle IEEE-754 single-precision divider, oz = ix / iy.
// Restoring bit-serial divide over 24-bit significands; denormals flush to zero, result truncates.
module float_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] ix,
    input  logic [31:0] iy,
    output logic [31:0] oz,
    output logic        Yichu,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0]  LastIter = 5'd24;
    localparam logic [31:0] NanVal   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {StIdle, StUnpack, StDiv, StNorm} state_e;

    state_e state_q, state_d;

    logic [31:0]       x_q, x_d;
    logic [31:0]       y_q, y_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       mb_q, mb_d;
    logic [24:0]       rem_q, rem_d;
    logic [24:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       oz_q, oz_d;
    logic              yichu_q, yichu_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Operand fields of the captured request.
    logic        sign;
    logic [7:0]  ex, ey;
    logic [22:0] mx, my;
    logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;

    assign sign   = x_q[31] ^ y_q[31];
    assign ex     = x_q[30:23];
    assign ey     = y_q[30:23];
    assign mx     = x_q[22:0];
    assign my     = y_q[22:0];
    assign x_zero = (ex == 8'h00);
    assign y_zero = (ey == 8'h00);
    assign x_inf  = (ex == 8'hFF) && (mx == 23'h0);
    assign y_inf  = (ey == 8'hFF) && (my == 23'h0);
    assign x_nan  = (ex == 8'hFF) && (mx != 23'h0);
    assign y_nan  = (ey == 8'hFF) && (my != 23'h0);

    // Special operands, resolved in priority order.
    logic        special;
    logic [31:0] special_oz;
    logic        special_yichu;

    always_comb begin
        special       = 1'b1;
        special_oz    = NanVal;
        special_yichu = 1'b0;
        if (x_nan || y_nan) begin
            special_oz = NanVal;
        end else if ((x_inf && y_inf) || (x_zero && y_zero)) begin
            special_oz = NanVal;
        end else if (x_inf) begin
            special_oz = {sign, 8'hFF, 23'h0};
        end else if (y_zero) begin
            special_oz    = {sign, 8'hFF, 23'h0};
            special_yichu = 1'b1;
        end else if (x_zero || y_inf) begin
            special_oz = {sign, 31'h0};
        end else begin
            special = 1'b0;
        end
    end

    logic signed [9:0] exp_raw;
    assign exp_raw = $signed({2'b00, ex}) - $signed({2'b00, ey}) + 10'sd127;

    // One restoring step: the remainder after subtraction is always below mb.
    logic        rem_ge;
    logic [24:0] rem_sub;
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    logic signed [9:0] exp_norm;
    logic [22:0]       mant_norm;
    assign exp_norm  = quo_q[24] ? exp_q : (exp_q - 10'sd1);
    assign mant_norm = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StUnpack;
            end
            StUnpack: begin
                state_d = special ? StIdle : StDiv;
            end
            StDiv: begin
                if (cnt_q == LastIter) state_d = StNorm;
            end
            StNorm: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        exp_d   = exp_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        oz_d    = oz_q;
        yichu_d = yichu_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d    = ix;
                    y_d    = iy;
                    busy_d = 1'b1;
                end
            end
            StUnpack: begin
                if (special) begin
                    oz_d    = special_oz;
                    yichu_d = special_yichu;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    exp_d = exp_raw;
                    mb_d  = {1'b1, my};
                    rem_d = {2'b01, mx};
                    quo_d = 25'h0;
                    cnt_d = 5'd0;
                end
            end
            StDiv: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[23:0], rem_ge};
                cnt_d = (cnt_q == LastIter) ? 5'd0 : (cnt_q + 5'd1);
            end
            StNorm: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (exp_norm >= 10'sd255) begin
                    oz_d    = {sign, 8'hFF, 23'h0};
                    yichu_d = 1'b1;
                end else if (exp_norm <= 10'sd0) begin
                    oz_d    = {sign, 31'h0};
                    yichu_d = 1'b0;
                end else begin
                    oz_d    = {sign, exp_norm[7:0], mant_norm};
                    yichu_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= 32'h0;
            y_q     <= 32'h0;
            exp_q   <= 10'sd0;
            mb_q    <= 24'h0;
            rem_q   <= 25'h0;
            quo_q   <= 25'h0;
            cnt_q   <= 5'd0;
            oz_q    <= 32'h0;
            yichu_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            exp_q   <= exp_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            oz_q    <= oz_d;
            yichu_q <= yichu_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oz    = oz_q;
    assign Yichu = yichu_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_float_div.sv
// Directed bench for float_div: hand-computed quotients, special operands and handshake timing.
module tb_float_div;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ix    = 32'h0;
    logic [31:0] iy    = 32'h0;
    logic [31:0] oz;
    logic        Yichu;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    float_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ix    (ix),
        .iy    (iy),
        .oz    (oz),
        .Yichu (Yichu),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the following rising edge is T0.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        ix    = x;
        iy    = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called just after T0; lat = k when done is seen after edge T0+k, -1 on timeout.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = busy;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_z, input logic exp_y, input int exp_lat);
        int   lat;
        logic bok;
        launch(x, y);
        wait_done(lat, bok);
        check({tag, " oz"}, oz, exp_z);
        check({tag, " Yichu"}, {31'b0, Yichu}, {31'b0, exp_y});
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy"}, {31'b0, bok}, 32'd1);
        @(negedge clk);
        check({tag, " done pulse"}, {31'b0, done}, 32'd0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int   lat;
        int   ndone;
        logic bok;

        repeat (3) @(negedge clk);
        check("reset oz", oz, 32'h0);
        check("reset ctl", {29'b0, Yichu, busy, done}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        run_op("6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);
        run_op("1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0, 27);
        run_op("-6/2", 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 1'b0, 27);
        run_op("-1/0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1);
        run_op("0/0", 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("inf/-inf", 32'h7F80_0000, 32'hFF80_0000, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("nan/1", 32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("nan/0", 32'h7FC0_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1);
        run_op("inf/-2", 32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1'b0, 1);
        run_op("-0/2", 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1);
        run_op("1/inf", 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1);
        run_op("ovf", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b1, 27);
        run_op("unf", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0, 27);

        // Second start during DIV is dropped and not queued.
        launch(32'h40C0_0000, 32'h4000_0000);
        repeat (9) @(negedge clk);
        ix    = 32'h3F80_0000;
        iy    = 32'h4040_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok);
        check("mid-div latency", 32'(lat), 32'd17);
        check("mid-div oz", oz, 32'h4040_0000);
        check("mid-div busy", {31'b0, bok}, 32'd1);
        count_done(40, ndone);
        check("mid-div no requeue", 32'(ndone), 32'd0);

        // Reset around T0+10 aborts silently and clears oz.
        launch(32'h3F80_0000, 32'h4040_0000);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort oz", oz, 32'h0);
        check("abort ctl", {29'b0, Yichu, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        count_done(40, ndone);
        check("abort no done", 32'(ndone), 32'd0);
        run_op("after abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 27);

        // Start presented in the done cycle is accepted.
        launch(32'h40C0_0000, 32'h4000_0000);
        wait_done(lat, bok);
        check("b2b first latency", 32'(lat), 32'd27);
        check("b2b first oz", oz, 32'h4040_0000);
        ix    = 32'h3F80_0000;
        iy    = 32'h4040_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bok);
        check("b2b second latency", 32'(lat), 32'd27);
        check("b2b second oz", oz, 32'h3EAA_AAAA);
        check("b2b second busy", {31'b0, bok}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
